// File: rtl/dac_sample_shaper.sv
// Gain-ramped sample shaper for an 8-bit R2R DAC: scales offset-binary samples by a ramping gain.
// Optional macro DAC_SLEW_LIMIT_EN limits the per-update change of dac_out to SLEW_MAX.
module dac_sample_shaper #(
  parameter int unsigned RAMP_STEP = 4,
  parameter int unsigned SLEW_MAX  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  input  logic [7:0] gain,
  input  logic       mute,
  output logic [7:0] dac_out,
  output logic       dac_update,
  output logic       muted
);

  typedef enum logic [1:0] {StMuted, StRampUp, StRun, StRampDown} state_e;

  localparam logic [8:0] Step = 9'(RAMP_STEP);

  if (RAMP_STEP < 1 || RAMP_STEP > 64 || SLEW_MAX < 1 || SLEW_MAX > 255) begin : g_param_check
    $error("dac_sample_shaper: RAMP_STEP or SLEW_MAX out of range");
  end

  state_e     state_q, state_d;
  logic [7:0] cur_gain_q, cur_gain_d;
  logic [7:0] dac_out_q, dac_next;
  logic       dac_update_q;

  // Ramp arithmetic in 9 bits so the carry/borrow is visible instead of wrapping.
  logic [8:0] gain_up, gain_dn;
  logic [7:0] up_val, dn_val, run_val;

  assign gain_up = {1'b0, cur_gain_q} + Step;
  assign gain_dn = {1'b0, cur_gain_q} - Step;
  assign up_val  = (gain_up > {1'b0, gain}) ? gain : gain_up[7:0];
  assign dn_val  = gain_dn[8] ? 8'd0 : gain_dn[7:0];

  always_comb begin
    run_val = cur_gain_q;
    if (gain > cur_gain_q) begin
      run_val = up_val;
    end else if (gain < cur_gain_q) begin
      run_val = (gain_dn[8] || (gain_dn[7:0] < gain)) ? gain : gain_dn[7:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_gain_d = cur_gain_q;
    if (sample_valid) begin
      unique case (state_q)
        StMuted: begin
          cur_gain_d = 8'd0;
          if (!mute) begin
            cur_gain_d = up_val;
            state_d    = (up_val == gain) ? StRun : StRampUp;
          end
        end
        StRampUp: begin
          if (mute) begin
            cur_gain_d = dn_val;
            state_d    = StRampDown;
          end else begin
            cur_gain_d = up_val;
            if (up_val == gain) state_d = StRun;
          end
        end
        StRun: begin
          if (mute) begin
            cur_gain_d = dn_val;
            state_d    = StRampDown;
          end else begin
            cur_gain_d = run_val;
          end
        end
        StRampDown: begin
          if (!mute) begin
            cur_gain_d = up_val;
            state_d    = (up_val == gain) ? StRun : StRampUp;
          end else begin
            cur_gain_d = dn_val;
            if (dn_val == 8'd0) state_d = StMuted;
          end
        end
        default: state_d = StMuted;
      endcase
    end
  end

  // Signed sample is the offset-binary code with its MSB flipped; the product fits 16 bits.
  logic [7:0]  s;
  logic [15:0] prod;
  logic [7:0]  target;

  assign s      = {~sample_in[7], sample_in[6:0]};
  assign prod   = {{8{s[7]}}, s} * {8'd0, cur_gain_q};
  assign target = 8'(prod >> 8) ^ 8'h80;

`ifdef DAC_SLEW_LIMIT_EN
  localparam logic signed [9:0] SlewLim = 10'(SLEW_MAX);

  logic signed [9:0] diff, delta;

  assign diff = $signed({2'b00, target}) - $signed({2'b00, dac_out_q});

  always_comb begin
    delta = diff;
    if (diff > SlewLim) begin
      delta = SlewLim;
    end else if (diff < -SlewLim) begin
      delta = -SlewLim;
    end
  end

  assign dac_next = 8'({2'b00, dac_out_q} + delta);
`else
  assign dac_next = target;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StMuted;
      cur_gain_q   <= 8'd0;
      dac_out_q    <= 8'd128;
      dac_update_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_gain_q   <= cur_gain_d;
      dac_update_q <= sample_valid;
      if (sample_valid) dac_out_q <= dac_next;
    end
  end

  assign dac_out    = dac_out_q;
  assign dac_update = dac_update_q;
  assign muted      = (state_q == StMuted);

endmodule

// File: tb/tb_dac_sample_shaper.sv
// Scoreboard bench for dac_sample_shaper: directed ramp scenarios plus randomized traffic.
module tb_dac_sample_shaper;
  localparam int RampStep = 4;
  localparam int SlewMax  = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic [7:0] gain;
  logic       mute;
  logic [7:0] dac_out;
  logic       dac_update;
  logic       muted;

  always #5 clk = ~clk;

  dac_sample_shaper #(
    .RAMP_STEP(RampStep),
    .SLEW_MAX (SlewMax)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .gain        (gain),
    .mute        (mute),
    .dac_out     (dac_out),
    .dac_update  (dac_update),
    .muted       (muted)
  );

  typedef struct {
    int due;
    int dac;
    int mut;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: 0 muted, 1 ramping up, 2 running, 3 ramping down.
  int m_state = 0;
  int m_gain  = 0;
  int m_dac   = 128;

  function automatic int floor_div256(input int p);
    return (p >= 0) ? p / 256 : -((-p + 255) / 256);
  endfunction

  function automatic exp_t model_valid(input int smp, input int g, input bit m);
    exp_t e;
    int   tgt, up, dn;
    tgt = 128 + floor_div256((smp - 128) * m_gain);
`ifdef DAC_SLEW_LIMIT_EN
    begin
      int d;
      d = tgt - m_dac;
      if (d > SlewMax) d = SlewMax;
      if (d < -SlewMax) d = -SlewMax;
      m_dac = m_dac + d;
    end
`else
    m_dac = tgt;
`endif
    up = (m_gain + RampStep < g) ? m_gain + RampStep : g;
    dn = (m_gain - RampStep > 0) ? m_gain - RampStep : 0;
    case (m_state)
      0: if (!m) begin m_gain = up; m_state = (up == g) ? 2 : 1; end
      1: if (m) begin m_gain = dn; m_state = 3; end
         else begin m_gain = up; if (up == g) m_state = 2; end
      2: if (m) begin m_gain = dn; m_state = 3; end
         else if (g > m_gain) m_gain = up;
         else m_gain = (m_gain - RampStep > g) ? m_gain - RampStep : g;
      default: if (!m) begin m_gain = up; m_state = (up == g) ? 2 : 1; end
               else begin m_gain = dn; if (dn == 0) m_state = 0; end
    endcase
    e.due = cyc + 1;
    e.dac = m_dac;
    e.mut = (m_state == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic send(input int smp, input int g, input bit m);
    @(negedge clk);
    sample_in    = 8'(smp);
    gain         = 8'(g);
    mute         = m;
    sample_valid = 1'b1;
    sbq.push_back(model_valid(smp, g, m));
  endtask

  task automatic settle();
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    sample_valid = 1'b0;
    sample_in    = 8'($urandom);
    gain         = 8'($urandom);
    mute         = 1'($urandom);
  endtask

  task automatic do_reset(input bit with_valid);
    @(negedge clk);
    rst_n        = 1'b0;
    sample_valid = with_valid;
    sample_in    = 8'($urandom);
    m_state      = 0;
    m_gain       = 0;
    m_dac        = 128;
    @(negedge clk);
    rst_n        = 1'b1;
    sample_valid = 1'b0;
    check("reset dac_out", dac_out, 128);
    check("reset dac_update", dac_update, 0);
    check("reset muted", muted, 1);
  endtask

  // Monitor: every cycle either the next expected update is due or dac_update must be low.
  initial begin
    exp_t e;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        e = sbq.pop_front();
        check("update strobe", dac_update, 1);
        check("dac_out", dac_out, e.dac);
        check("muted", muted, e.mut);
      end else begin
        check("idle strobe", dac_update, 0);
      end
    end
  end

  initial begin
    int g_cur;
    bit m_cur;
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    sample_in    = 8'd0;
    gain         = 8'd0;
    mute         = 1'b1;
    repeat (2) @(negedge clk);
    check("por dac_out", dac_out, 128);
    check("por dac_update", dac_update, 0);
    check("por muted", muted, 1);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Muted: full-scale samples stay at midscale.
    repeat (10) send(255, 255, 1);
    settle();
    check("muted hold", muted, 1);
    check("muted midscale", dac_out, 128);

    // Ramp to unity gain, then exercise extremes.
    repeat (64) send(128, 255, 0);
`ifdef DAC_SLEW_LIMIT_EN
    repeat (8) send(255, 255, 0);
    settle();
    check("slew reaches full", dac_out, 254);
    send(0, 255, 0);
    send(128, 255, 0);
`else
    send(255, 255, 0);
    settle();
    check("unity full", dac_out, 254);
    send(0, 255, 0);
    settle();
    check("unity zero", dac_out, 0);
    send(128, 255, 0);
    settle();
    check("unity mid", dac_out, 128);
`endif

    // Lower gain to 128 in RUN.
    repeat (32) send(128, 128, 0);
`ifndef DAC_SLEW_LIMIT_EN
    send(255, 128, 0);
    settle();
    check("half gain high", dac_out, 191);
    send(0, 128, 0);
    settle();
    check("half gain low", dac_out, 64);
`endif

    // Back to unity, then mute fully.
    repeat (32) send(128, 255, 0);
    repeat (64) send(128, 255, 1);
    settle();
    check("muted after ramp", muted, 1);
    check("muted dac", dac_out, 128);

    // Ramp to 200, ramp down to 100, then unmute mid-ramp.
    repeat (50) send(128, 200, 0);
    repeat (25) send(128, 200, 1);
`ifndef DAC_SLEW_LIMIT_EN
    send(255, 200, 0);
    settle();
    check("gain 100 output", dac_out, 177);
    send(255, 200, 0);
    settle();
    check("gain 104 output", dac_out, 179);
    check("ramping not muted", muted, 0);
`else
    repeat (2) send(255, 200, 0);
`endif

    // Reset coincident with a valid, mid-RAMP_UP.
    do_reset(1'b1);
    send(128, 255, 0);

    g_cur = 255;
    m_cur = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r < 15) m_cur = ~m_cur;
      else if (r < 25) g_cur = int'($urandom_range(0, 255));
      if (r < 6) do_reset(1'($urandom));
      else if (r < 650) send(int'($urandom_range(0, 255)), g_cur, m_cur);
      else idle_cycle();
    end

    repeat (3) idle_cycle();
    check("scoreboard drained", 32'(sbq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dac_sample_shaper.md
DAC_SAMPLE_SHAPER -- requirements
Module: dac_sample_shaper

Interface
REQ-001 SHALL have parameter RAMP_STEP, default 4: gain change per accepted sample (1..64).
REQ-002 SHALL have parameter SLEW_MAX, default 16: max dac_out change per update; used only with DAC_SLEW_LIMIT_EN.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port sample_in  input  8  offset-binary sample from the sine lookup (128 = midscale).
REQ-006 SHALL have port sample_valid  input  1  one-cycle strobe marking a new sample_in.
REQ-007 SHALL have port gain  input  8  target amplitude (255 ≈ unity, 0 = silent).
REQ-008 SHALL have port mute  input  1  level; 1 requests a ramp to silence.
REQ-009 SHALL have port dac_out  output  8  registered code driving the R2R DAC pins.
REQ-010 SHALL have port dac_update  output  1  high for one cycle after each dac_out load.
REQ-011 SHALL have port muted  output  1  high while in state MUTED.

Function
REQ-012 SHALL hold an 8-bit register cur_gain and a state machine with states MUTED, RAMP_UP, RUN, RAMP_DOWN.
REQ-013 SHALL change state, cur_gain, dac_out and dac_update only on edges where sample_valid=1, except dac_update clearing and reset.
REQ-014 SHALL compute s = sample_in - 128 (signed 9-bit), p = s * cur_gain (signed 17-bit), target = 128 + (p arithmetic-shift-right 8), floor rounding; target is always in 0..254, so no saturation is needed.
REQ-015 SHALL compute target with the cur_gain value held before that edge's ramp update.
REQ-016 SHALL load dac_out on the edge sampling sample_valid=1 (latency 1 clock) and hold dac_update=1 for exactly the following cycle.
REQ-017 SHALL keep dac_update high continuously when sample_valid is high on consecutive cycles.
REQ-018 MUTED: cur_gain=0; if mute=0 go to RAMP_UP.
REQ-019 RAMP_UP: cur_gain <= min(cur_gain+RAMP_STEP, gain); if the result equals gain go to RUN.
REQ-020 RUN: cur_gain steps toward gain by at most RAMP_STEP without overshoot.
REQ-021 RAMP_DOWN: cur_gain <= max(cur_gain-RAMP_STEP, 0); if the result is 0 go to MUTED.
REQ-022 In RAMP_UP or RUN, mute=1 SHALL transition to RAMP_DOWN, and that edge SHALL take the RAMP_DOWN decrement.
REQ-023 In RAMP_DOWN, mute=0 SHALL transition to RAMP_UP, and that edge SHALL take the RAMP_UP increment.
REQ-024 SHALL use 9-bit intermediates for the ramp arithmetic so cur_gain never wraps.
REQ-025 SHALL leave dac_out, cur_gain and state unchanged when sample_valid=0, whatever mute and gain do.

Reset
REQ-026 SHALL, on any edge with rst_n=0, set state=MUTED, cur_gain=0, dac_out=128, dac_update=0, muted=1, overriding sample_valid.
REQ-027 SHALL apply reset mid-ramp or mid-run with no partial update.

Configuration
REQ-028 With macro DAC_SLEW_LIMIT_EN defined, dac_out SHALL load dac_out + clamp(target - dac_out, -SLEW_MAX, +SLEW_MAX).
REQ-029 Without DAC_SLEW_LIMIT_EN, dac_out SHALL load target directly, SLEW_MAX SHALL be unused, and no slew logic SHALL be synthesised.

Verification
REQ-030 Reset with mute=1, 10 valids of sample_in=255 -> dac_out=128 every update, muted=1, dac_update pulses one cycle after each valid.
REQ-031 gain=255, mute=0, RAMP_STEP=4, continuous valids -> cur_gain 4,8,...,252,255; RUN entered on the 64th valid; then sample_in=255 -> 254, 0 -> 0, 128 -> 128.
REQ-032 In RUN with gain=128 -> cur_gain drops by 4 per valid to 128; then sample_in=255 -> dac_out=191, sample_in=0 -> dac_out=64.
REQ-033 In RUN at 255, assert mute -> 64 valids to cur_gain=0, then MUTED, muted=1, dac_out=128; deassert mute mid-ramp at cur_gain=100 -> next valid gives 104 in RAMP_UP.
REQ-034 rst_n=0 for one cycle coincident with sample_valid, mid-RAMP_UP -> next cycle dac_out=128, dac_update=0, cur_gain=0, MUTED.
REQ-035 DAC_SLEW_LIMIT_EN, SLEW_MAX=16, RUN at 255, sample_in steps 128->255 -> dac_out 144,160,...,240,254; without the macro -> 254 on the first update.
